// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: state encoding, Q16.16 saturation values, defaults.
// Pure declarations; no latency or backpressure of its own.
package div_arb_pkg;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        ZRESP = 2'd3
    } arb_state_t;

    localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN = 32'h8000_0000;

    localparam int DEF_NREQ         = 4;
    localparam int DEF_FLUSH_CYCLES = 40;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NREQ.
// Purely combinational (zero latency); no backpressure.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any
);

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin : scan
            logic [PW-1:0] j;
            j = PW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                winner = j;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one iterative Q16.16 divider; DIV_ARBITER_ZERO_BYPASS_EN answers d==0 locally.
// Latency: ack one cycle after req is sampled, rsp_valid one cycle after div_done; req is ignored while busy.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int W            = 32,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] n_in,
    input  logic [NREQ*W-1:0] d_in,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_q,
    output logic              rsp_dz,
    output logic              busy,
    output logic              div_start,
    output logic [W-1:0]      div_n,
    output logic [W-1:0]      div_d,
    input  logic [W-1:0]      div_q,
    input  logic              div_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic          any;
    logic [CW-1:0] flush_cnt;
    logic [W-1:0]  win_n;
    logic [W-1:0]  win_d;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .any    (any)
    );

    assign win_n = n_in[win*W +: W];
    assign win_d = d_in[win*W +: W];
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FLUSH;
            ptr       <= '0;
            idx       <= '0;
            flush_cnt <= '0;
            ack       <= '0;
            rsp_valid <= '0;
            rsp_q     <= '0;
            rsp_dz    <= 1'b0;
            div_start <= 1'b0;
            div_n     <= '0;
            div_d     <= '0;
        end else begin
            ack       <= '0;
            rsp_valid <= '0;
            div_start <= 1'b0;
            case (state)
                // The divider has no reset, so a done pulse from before reset must drain here.
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == CW'(FLUSH_CYCLES - 1)) state <= IDLE;
                end
                IDLE: begin
                    if (any) begin
                        ack   <= ONE << win;
                        idx   <= win;
                        div_n <= win_n;
                        div_d <= win_d;
                        ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
                        if (win_d == '0) begin
                            state <= ZRESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= WAIT;
                        end
`else
                        div_start <= 1'b1;
                        state     <= WAIT;
`endif
                    end
                end
                WAIT: begin
                    if (div_done) begin
                        rsp_q     <= div_q;
                        rsp_dz    <= 1'b0;
                        rsp_valid <= ONE << idx;
                        state     <= IDLE;
                    end
                end
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
                ZRESP: begin
                    rsp_q     <= div_n[W-1] ? W'(QMIN) : W'(QMAX);
                    rsp_dz    <= 1'b1;
                    rsp_valid <= ONE << idx;
                    state     <= IDLE;
                end
`endif
                default: state <= FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a fixed-latency divider model; zero-divisor checks follow DIV_ARBITER_ZERO_BYPASS_EN.
module tb_div_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 32;
    localparam int FLUSH = 12;
    localparam int DLAT  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] n_in;
    logic [NREQ*W-1:0] d_in;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_q;
    logic              rsp_dz;
    logic              busy;
    logic              div_start;
    logic [W-1:0]      div_n;
    logic [W-1:0]      div_d;
    logic [W-1:0]      div_q = '0;
    logic              div_done = 1'b0;

    logic [31:0] cn [4];
    logic [31:0] cd [4];
    assign n_in = {cn[3], cn[2], cn[1], cn[0]};
    assign d_in = {cd[3], cd[2], cd[1], cd[0]};

    int   total  = 0;
    int   passed = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    div_arbiter #(.NREQ(NREQ), .W(W), .FLUSH_CYCLES(FLUSH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .n_in      (n_in),
        .d_in      (d_in),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .rsp_dz    (rsp_dz),
        .busy      (busy),
        .div_start (div_start),
        .div_n     (div_n),
        .div_d     (div_d),
        .div_q     (div_q),
        .div_done  (div_done)
    );

    function automatic logic [31:0] qdiv(input logic [31:0] n, input logic [31:0] d);
        logic signed [63:0] a;
        logic signed [63:0] b;
        logic signed [63:0] r;
        if (d == 32'h0) return 32'h1234_5678;
        a = {{16{n[31]}}, n, 16'h0};
        b = {{32{d[31]}}, d};
        r = a / b;
        return r[31:0];
    endfunction

    // Divider stand-in: no reset, fixed latency, like the real iterative unit.
    int         m_cnt  = 0;
    bit         m_busy = 1'b0;
    logic [31:0] m_n   = '0;
    logic [31:0] m_d   = '0;
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (div_start === 1'b1) begin
            m_n    <= div_n;
            m_d    <= div_d;
            m_cnt  <= DLAT - 1;
            m_busy <= 1'b1;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                div_done <= 1'b1;
                div_q    <= qdiv(m_n, m_d);
                m_busy   <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        done_prev = div_done;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int bound, output int n);
        n = 0;
        while (ack == '0 && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rsp(input int bound, output int n);
        n = 0;
        while (rsp_valid == '0 && n < bound) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        int          grant;
        logic [31:0] q;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int         n;
        logic [3:0] oh;
        logic [3:0] saw_ack;
        logic [3:0] saw_rsp;
        logic       saw_start;
        logic       saw_done;

        tbl[0] = '{4'b1111, 0, 32'h0001_8000};
        tbl[1] = '{4'b1111, 1, 32'h0002_8000};
        tbl[2] = '{4'b1111, 2, 32'hFFFF_8000};
        tbl[3] = '{4'b1111, 3, 32'h0004_0000};
        tbl[4] = '{4'b1111, 0, 32'h0001_8000};
        tbl[5] = '{4'b0010, 1, 32'h0002_8000};
        tbl[6] = '{4'b0011, 0, 32'h0001_8000};
        tbl[7] = '{4'b0011, 1, 32'h0002_8000};

        cn[0] = 32'h0003_0000; cd[0] = 32'h0002_0000;
        cn[1] = 32'h000A_0000; cd[1] = 32'h0004_0000;
        cn[2] = 32'hFFFF_0000; cd[2] = 32'h0002_0000;
        cn[3] = 32'h0001_0000; cd[3] = 32'h0000_4000;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",       64'(ack),       64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_q",     64'(rsp_q),     64'(0));
        chk("rst_rsp_dz",    64'(rsp_dz),    64'(0));
        chk("rst_div_start", 64'(div_start), 64'(0));
        chk("rst_div_n",     64'(div_n),     64'(0));
        chk("rst_div_d",     64'(div_d),     64'(0));
        chk("rst_busy",      64'(busy),      64'(1));

        // Request held from the first cycle after reset: granted only after the flush window.
        rst = 1'b0;
        req = 4'b0001;
        wait_ack(FLUSH + 20, n);
        chk("flush_len",   64'(n),         64'(FLUSH + 1));
        chk("first_ack",   64'(ack),       64'(4'b0001));
        chk("first_start", 64'(div_start), 64'(1));
        chk("first_div_n", 64'(div_n),     64'(cn[0]));
        chk("first_div_d", 64'(div_d),     64'(cd[0]));
        req = 4'b0000;
        tick();
        chk("ack_pulse",   64'(ack),       64'(0));
        chk("start_pulse", 64'(div_start), 64'(0));
        wait_rsp(4 * DLAT, n);
        chk("first_rsp",      64'(rsp_valid), 64'(4'b0001));
        chk("first_q",        64'(rsp_q),     64'(32'h0001_8000));
        chk("first_dz",       64'(rsp_dz),    64'(0));
        chk("rsp_after_done", 64'(done_prev), 64'(1));
        tick();
        chk("rsp_pulse", 64'(rsp_valid), 64'(0));
        chk("q_held",    64'(rsp_q),     64'(32'h0001_8000));

        // Fresh reset so round-robin starts from client 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy && n < FLUSH + 10) begin
            tick();
            n++;
        end
        chk("reflush_len", 64'(n), 64'(FLUSH));

        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req;
            oh  = 4'b0001 << tbl[i].grant;
            wait_ack(4 * DLAT, n);
            chk($sformatf("tbl%0d_gap", i),   64'(n),         64'(1));
            chk($sformatf("tbl%0d_ack", i),   64'(ack),       64'(oh));
            chk($sformatf("tbl%0d_start", i), 64'(div_start), 64'(1));
            chk($sformatf("tbl%0d_div_n", i), 64'(div_n),     64'(cn[tbl[i].grant]));
            wait_rsp(4 * DLAT, n);
            chk($sformatf("tbl%0d_rsp", i),   64'(rsp_valid), 64'(oh));
            chk($sformatf("tbl%0d_q", i),     64'(rsp_q),     64'(tbl[i].q));
        end
        req = 4'b0000;

        // ptr is 2: client 2 wins, client 1 withdraws just before it would be granted.
        req = 4'b0110;
        wait_ack(4 * DLAT, n);
        chk("drop_grant2", 64'(ack), 64'(4'b0100));
        req = 4'b0010;
        n = 0;
        while (div_done !== 1'b1 && n < 4 * DLAT) begin
            tick();
            n++;
        end
        chk("drop_saw_done", 64'(div_done), 64'(1));
        req = 4'b0000;
        saw_ack = '0; saw_rsp = '0; saw_start = 1'b0;
        repeat (2 * DLAT) begin
            tick();
            saw_ack   |= ack;
            saw_rsp   |= rsp_valid;
            saw_start |= div_start;
        end
        chk("drop_no_ack",   64'(saw_ack),   64'(0));
        chk("drop_no_start", 64'(saw_start), 64'(0));
        chk("drop_rsp2",     64'(saw_rsp),   64'(4'b0100));

        // Reset while the divider is mid-operation; its late done must be discarded.
        req = 4'b0001;
        wait_ack(4 * DLAT, n);
        chk("rstw_grant", 64'(ack), 64'(4'b0001));
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstw_ack",   64'(ack),       64'(0));
        chk("rstw_start", 64'(div_start), 64'(0));
        chk("rstw_div_n", 64'(div_n),     64'(0));
        chk("rstw_q",     64'(rsp_q),     64'(0));
        chk("rstw_busy",  64'(busy),      64'(1));
        tick();
        rst = 1'b0;
        saw_ack = '0; saw_rsp = '0; saw_done = 1'b0;
        repeat (FLUSH) begin
            tick();
            saw_ack  |= ack;
            saw_rsp  |= rsp_valid;
            saw_done |= div_done;
        end
        chk("rstw_saw_done", 64'(saw_done), 64'(1));
        chk("rstw_no_rsp",   64'(saw_rsp),  64'(0));
        chk("rstw_no_ack",   64'(saw_ack),  64'(0));
        chk("rstw_q_after",  64'(rsp_q),    64'(0));
        chk("rstw_idle",     64'(busy),     64'(0));

        // Zero divisor with a negative dividend.
        cn[0] = 32'hFFFF_0000;
        cd[0] = 32'h0000_0000;
        req = 4'b0001;
        wait_ack(4 * DLAT, n);
        chk("zd_ack", 64'(ack), 64'(4'b0001));
        req = 4'b0000;
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
        chk("zd_no_start", 64'(div_start), 64'(0));
        tick();
        chk("zd_rsp", 64'(rsp_valid), 64'(4'b0001));
        chk("zd_q",   64'(rsp_q),     64'(32'h8000_0000));
        chk("zd_dz",  64'(rsp_dz),    64'(1));
`else
        chk("zd_start", 64'(div_start), 64'(1));
        wait_rsp(4 * DLAT, n);
        chk("zd_rsp", 64'(rsp_valid), 64'(4'b0001));
        chk("zd_q",   64'(rsp_q),     64'(32'h1234_5678));
        chk("zd_dz",  64'(rsp_dz),    64'(0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1);
    end

endmodule
